// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle MIPS control FSM and its datapath.
// The controller reads the instruction fields and drives every enable/select.
interface controle_multiciclo_if;
    logic [5:0] OPcode;
    logic [5:0] funct;
    logic       EscreveMem;
    logic       EscrevePC;
    logic       EscrevePCCond;
    logic [1:0] OrigPC;
    logic       RegDst;
    logic       EscreveReg;
    logic [1:0] MemparaReg;
    logic       IouD;
    logic       EscreveIR;
    logic       EscreveMDR;
    logic       EscreveAluOut;
    logic       OrigAALU;
    logic [1:0] OrigBALU;
    logic [2:0] OpALU;
    logic       InstInvalida;
    logic [5:0] State;

    // Controller side: samples IR fields, drives the control word.
    modport master (
        input  OPcode, funct,
        output EscreveMem, EscrevePC, EscrevePCCond, OrigPC, RegDst,
               EscreveReg, MemparaReg, IouD, EscreveIR, EscreveMDR,
               EscreveAluOut, OrigAALU, OrigBALU, OpALU, InstInvalida, State
    );

    // Datapath side: supplies IR fields, consumes the control word.
    modport slave (
        output OPcode, funct,
        input  EscreveMem, EscrevePC, EscrevePCCond, OrigPC, RegDst,
               EscreveReg, MemparaReg, IouD, EscreveIR, EscreveMDR,
               EscreveAluOut, OrigAALU, OrigBALU, OpALU, InstInvalida, State
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Moore control FSM for the multicycle MIPS datapath.
// The control word is registered together with the state, so every output is
// a pure function of the state register and glitch-free.
module controle_multiciclo (
    input  logic                    clock,
    input  logic                    reset,
    controle_multiciclo_if.master   bus
);

    typedef enum logic [5:0] {
        S_RESET    = 6'd0,
        FETCH      = 6'd1,
        FETCH_WAIT = 6'd2,
        DECODE     = 6'd3,
        MEM_ADDR   = 6'd4,
        LW_READ    = 6'd5,
        LW_WAIT    = 6'd6,
        LW_WB      = 6'd7,
        SW_WRITE   = 6'd8,
        R_EXEC     = 6'd9,
        R_WB       = 6'd10,
        BEQ        = 6'd11,
        JUMP       = 6'd12,
        ADDI_EXEC  = 6'd13,
        ADDI_WB    = 6'd14,
        INVALID    = 6'd15
    } state_t;

    typedef struct packed {
        logic       escreve_mem;
        logic       escreve_pc;
        logic       escreve_pc_cond;
        logic [1:0] orig_pc;
        logic       reg_dst;
        logic       escreve_reg;
        logic [1:0] mem_para_reg;
        logic       iou_d;
        logic       escreve_ir;
        logic       escreve_mdr;
        logic       escreve_alu_out;
        logic       orig_a_alu;
        logic [1:0] orig_b_alu;
        logic [2:0] op_alu;
        logic       inst_invalida;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t state;
    ctrl_t  ctrl;

    // R-type functs the datapath ALU implements: add, sub, and, or, slt.
    function automatic logic funct_ok(input logic [5:0] fn);
        return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
               (fn == 6'h25) || (fn == 6'h2A);
    endfunction

    // Transition function; IR fields only matter in DECODE and MEM_ADDR.
    function automatic state_t next_state(input state_t s,
                                          input logic [5:0] op,
                                          input logic [5:0] fn);
        state_t n;
        n = S_RESET;
        case (s)
            S_RESET:    n = FETCH;
            FETCH:      n = FETCH_WAIT;
            FETCH_WAIT: n = DECODE;
            DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (fn == 6'h00)      n = FETCH;
                        else if (funct_ok(fn)) n = R_EXEC;
                        else                  n = INVALID;
                    end
                    OP_LW, OP_SW: n = MEM_ADDR;
                    OP_BEQ:       n = BEQ;
                    OP_J:         n = JUMP;
                    OP_ADDI:      n = ADDI_EXEC;
                    default:      n = INVALID;
                endcase
            end
            MEM_ADDR:   n = (op == OP_LW) ? LW_READ : SW_WRITE;
            LW_READ:    n = LW_WAIT;
            LW_WAIT:    n = LW_WB;
            LW_WB:      n = FETCH;
            SW_WRITE:   n = FETCH;
            R_EXEC:     n = R_WB;
            R_WB:       n = FETCH;
            BEQ:        n = FETCH;
            JUMP:       n = FETCH;
            ADDI_EXEC:  n = ADDI_WB;
            ADDI_WB:    n = FETCH;
            INVALID:    n = INVALID;
            default:    n = S_RESET;   // codes 16-63 recover via reset state
        endcase
        return n;
    endfunction

    // Control word asserted while sitting in state s.
    function automatic ctrl_t decode_outputs(input state_t s);
        ctrl_t c;
        // NOTE: zero the whole word first so every state only lists what it
        // asserts and no path leaves a field unassigned.
        c = '0;
        case (s)
            FETCH: begin
                c.orig_b_alu = 2'b01;
                c.escreve_pc = 1'b1;
            end
            FETCH_WAIT: c.escreve_ir = 1'b1;
            DECODE: begin
                c.orig_b_alu      = 2'b11;
                c.escreve_alu_out = 1'b1;
            end
            MEM_ADDR: begin
                c.orig_a_alu      = 1'b1;
                c.orig_b_alu      = 2'b10;
                c.escreve_alu_out = 1'b1;
            end
            LW_READ: c.iou_d = 1'b1;
            LW_WAIT: begin
                c.iou_d       = 1'b1;
                c.escreve_mdr = 1'b1;
            end
            LW_WB: begin
                c.mem_para_reg = 2'b01;
                c.escreve_reg  = 1'b1;
            end
            SW_WRITE: begin
                c.iou_d       = 1'b1;
                c.escreve_mem = 1'b1;
            end
            R_EXEC: begin
                c.orig_a_alu      = 1'b1;
                c.op_alu          = 3'b010;
                c.escreve_alu_out = 1'b1;
            end
            R_WB: begin
                c.reg_dst     = 1'b1;
                c.escreve_reg = 1'b1;
            end
            BEQ: begin
                c.orig_a_alu      = 1'b1;
                c.op_alu          = 3'b001;
                c.orig_pc         = 2'b01;
                c.escreve_pc_cond = 1'b1;
            end
            JUMP: begin
                c.orig_pc    = 2'b10;
                c.escreve_pc = 1'b1;
            end
            ADDI_EXEC: begin
                c.orig_a_alu      = 1'b1;
                c.orig_b_alu      = 2'b10;
                c.escreve_alu_out = 1'b1;
            end
            ADDI_WB: c.escreve_reg = 1'b1;
            INVALID: c.inst_invalida = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // State and registered control word advance together; reset clears both
    // immediately so an in-flight write enable drops without waiting for clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
            ctrl  <= '0;
        end else begin
            // NOTE: non-blocking so state and ctrl both see the old state value.
            state <= next_state(state, bus.OPcode, bus.funct);
            ctrl  <= decode_outputs(next_state(state, bus.OPcode, bus.funct));
        end
    end

    assign bus.EscreveMem    = ctrl.escreve_mem;
    assign bus.EscrevePC     = ctrl.escreve_pc;
    assign bus.EscrevePCCond = ctrl.escreve_pc_cond;
    assign bus.OrigPC        = ctrl.orig_pc;
    assign bus.RegDst        = ctrl.reg_dst;
    assign bus.EscreveReg    = ctrl.escreve_reg;
    assign bus.MemparaReg    = ctrl.mem_para_reg;
    assign bus.IouD          = ctrl.iou_d;
    assign bus.EscreveIR     = ctrl.escreve_ir;
    assign bus.EscreveMDR    = ctrl.escreve_mdr;
    assign bus.EscreveAluOut = ctrl.escreve_alu_out;
    assign bus.OrigAALU      = ctrl.orig_a_alu;
    assign bus.OrigBALU      = ctrl.orig_b_alu;
    assign bus.OpALU         = ctrl.op_alu;
    assign bus.InstInvalida  = ctrl.inst_invalida;
    assign bus.State         = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: expected state codes are queued
// as each instruction is presented and compared, with the full control word,
// one cycle at a time.
module tb_controle_multiciclo;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   exp_q[$];

    controle_multiciclo_if bus();

    controle_multiciclo dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed control word, packed in a fixed order.
    function automatic logic [19:0] obs_vec();
        return {bus.EscreveMem, bus.EscrevePC, bus.EscrevePCCond, bus.OrigPC,
                bus.RegDst, bus.EscreveReg, bus.MemparaReg, bus.IouD,
                bus.EscreveIR, bus.EscreveMDR, bus.EscreveAluOut, bus.OrigAALU,
                bus.OrigBALU, bus.OpALU, bus.InstInvalida};
    endfunction

    // Reference control word per state code, from the state table.
    function automatic logic [19:0] exp_vec(input int s);
        logic       mem, pc, pcc, rd, reg_w, iou, ir, mdr, alo, a, inv;
        logic [1:0] opc, mpr, b;
        logic [2:0] op;
        {mem, pc, pcc, rd, reg_w, iou, ir, mdr, alo, a, inv} = '0;
        opc = 2'b00; mpr = 2'b00; b = 2'b00; op = 3'b000;
        case (s)
            1:  begin b = 2'b01; pc = 1'b1; end
            2:  ir = 1'b1;
            3:  begin b = 2'b11; alo = 1'b1; end
            4:  begin a = 1'b1; b = 2'b10; alo = 1'b1; end
            5:  iou = 1'b1;
            6:  begin iou = 1'b1; mdr = 1'b1; end
            7:  begin mpr = 2'b01; reg_w = 1'b1; end
            8:  begin iou = 1'b1; mem = 1'b1; end
            9:  begin a = 1'b1; op = 3'b010; alo = 1'b1; end
            10: begin rd = 1'b1; reg_w = 1'b1; end
            11: begin a = 1'b1; op = 3'b001; opc = 2'b01; pcc = 1'b1; end
            12: begin opc = 2'b10; pc = 1'b1; end
            13: begin a = 1'b1; b = 2'b10; alo = 1'b1; end
            14: reg_w = 1'b1;
            15: inv = 1'b1;
            default: ;
        endcase
        return {mem, pc, pcc, opc, rd, reg_w, mpr, iou, ir, mdr, alo, a, b, op, inv};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare state code and control word against the reference for s.
    task automatic check_state(input string tag, input int s);
        check({tag, ".state"}, {26'd0, bus.State}, s);
        check({tag, ".ctrl"}, {12'd0, obs_vec()}, {12'd0, exp_vec(s)});
    endtask

    // Advance one clock per queued expectation and compare just after the edge.
    task automatic drain(input string tag);
        int s;
        while (exp_q.size() > 0) begin
            @(posedge clock);
            #1;
            s = exp_q.pop_front();
            check_state(tag, s);
        end
    endtask

    task automatic push_seq(input int seq[$]);
        foreach (seq[i]) exp_q.push_back(seq[i]);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.OPcode = 6'h00;
        bus.funct  = 6'h20;

        // Held in reset: state 0, everything low.
        repeat (2) @(posedge clock);
        #1;
        check_state("reset", 0);

        // R-type add from reset release.
        release_reset();
        push_seq('{1, 2, 3, 9, 10, 1});
        drain("rtype");

        // lw
        bus.OPcode = 6'h23;
        push_seq('{2, 3, 4, 5, 6, 7, 1});
        drain("lw");

        // sw
        bus.OPcode = 6'h2B;
        push_seq('{2, 3, 4, 8, 1});
        drain("sw");

        // beq
        bus.OPcode = 6'h04;
        push_seq('{2, 3, 11, 1});
        drain("beq");

        // j
        bus.OPcode = 6'h02;
        push_seq('{2, 3, 12, 1});
        drain("jump");

        // nop
        bus.OPcode = 6'h00;
        bus.funct  = 6'h00;
        push_seq('{2, 3, 1});
        drain("nop");

        // addi
        bus.OPcode = 6'h08;
        push_seq('{2, 3, 13, 14, 1});
        drain("addi");

        // Unsupported opcode: halt in INVALID for 20 cycles.
        bus.OPcode = 6'h3F;
        push_seq('{2, 3, 15});
        repeat (20) exp_q.push_back(15);
        drain("inv_op");
        reset = 1'b1;
        #1;
        check_state("inv_op_reset", 0);
        release_reset();
        push_seq('{1});
        drain("inv_op_refetch");

        // Unsupported R-type funct: same halt behaviour.
        bus.OPcode = 6'h00;
        bus.funct  = 6'h03;
        push_seq('{2, 3, 15});
        repeat (20) exp_q.push_back(15);
        drain("inv_fn");
        reset = 1'b1;
        #1;
        check_state("inv_fn_reset", 0);
        release_reset();
        push_seq('{1});
        drain("inv_fn_refetch");

        // Reset in the middle of SW_WRITE: EscreveMem must drop before the next edge.
        bus.OPcode = 6'h2B;
        bus.funct  = 6'h00;
        push_seq('{2, 3, 4, 8});
        drain("sw_abort");
        #2;
        reset = 1'b1;
        #1;
        check("sw_abort.mem_drop", {31'd0, bus.EscreveMem}, 32'd0);
        check_state("sw_abort_reset", 0);
        release_reset();
        push_seq('{1, 2});
        drain("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
